// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// request/grant, then a read-data-valid response for loads.
interface load_store_unit_if;
  logic        Bus_Req_o;
  logic        Bus_We_o;
  logic [31:0] Bus_Addr_o;
  logic [31:0] Bus_WData_o;
  logic [3:0]  Bus_Be_o;
  logic        Bus_Gnt_i;
  logic        Bus_RValid_i;
  logic [31:0] Bus_RData_i;

  modport master (
    output Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_WData_o, Bus_Be_o,
    input  Bus_Gnt_i, Bus_RValid_i, Bus_RData_i
  );

  modport slave (
    input  Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_WData_o, Bus_Be_o,
    output Bus_Gnt_i, Bus_RValid_i, Bus_RData_i
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: turns LB/LH/LW/LBU/LHU/SB/SH/SW into a bus transaction.
// Optional bus-timeout abort is enabled by defining LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for Mem_Req_i; access checked and captured here
// REQ   | Bus_Req_o high, bus fields held until grant
// RESP  | load granted, waiting for Bus_RValid_i
// DONE  | one-cycle completion pulse, datapath released
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Req_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Store_Data_i,
  output logic        Stall_o,
  output logic        Done_o,
  output logic [31:0] Load_Data_o,
  output logic        Misaligned_o,
  output logic        Timeout_o,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] ld_q;
  logic        mis_q;

  logic        misaligned, illegal, bad_access;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;
  logic        tmo_hit;
  logic        tmo_abort;
  logic        accept;

  assign accept = (state_q == IDLE) && Mem_Req_i;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (Funct3_i)
      3'b000, 3'b100: ;
      3'b001, 3'b101: misaligned = Address_i[0];
      3'b010:         misaligned = |Address_i[1:0];
      default:        illegal = 1'b1;
    endcase
    // Unsigned variants have no store counterpart.
    if (Mem_Write_i && Funct3_i[2])
      illegal = 1'b1;
  end

  assign bad_access = misaligned | illegal;

  always_comb begin
    st_wdata = Store_Data_i;
    st_be    = 4'b1111;
    if (Mem_Write_i) begin
      case (Funct3_i[1:0])
        2'b00: begin
          st_wdata = {4{Store_Data_i[7:0]}};
          st_be    = 4'b0001 << Address_i[1:0];
        end
        2'b01: begin
          st_wdata = {2{Store_Data_i[15:0]}};
          st_be    = Address_i[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Halfword lanes are always even, so one shift serves both byte and halfword.
  assign rd_shift = bus.Bus_RData_i >> {lane_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
      default: ld_ext = bus.Bus_RData_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tmo_abort = 1'b0;
    case (state_q)
      IDLE: if (Mem_Req_i) state_d = bad_access ? DONE : REQ;
      REQ: begin
        if (bus.Bus_Gnt_i)
          state_d = we_q ? DONE : RESP;
        else if (tmo_hit) begin
          state_d   = DONE;
          tmo_abort = 1'b1;
        end
      end
      RESP: begin
        if (bus.Bus_RValid_i)
          state_d = DONE;
        else if (tmo_hit) begin
          state_d   = DONE;
          tmo_abort = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      ld_q     <= 32'd0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mis_q <= bad_access;
        if (!bad_access) begin
          we_q     <= Mem_Write_i;
          funct3_q <= Funct3_i;
          lane_q   <= Address_i[1:0];
          addr_q   <= {Address_i[31:2], 2'b00};
          wdata_q  <= st_wdata;
          be_q     <= st_be;
        end
      end
      if ((state_q == RESP) && bus.Bus_RValid_i)
        ld_q <= ld_ext;
      else if (tmo_abort && !we_q)
        ld_q <= 32'd0;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_inc;
  logic        tmo_q;

  assign tmo_cnt_inc = tmo_cnt_q + 16'd1;
  assign tmo_hit     = ((state_q == REQ) || (state_q == RESP)) && (tmo_cnt_inc == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= 16'd0;
      tmo_q     <= 1'b0;
    end else begin
      if ((state_q == REQ) || (state_q == RESP))
        tmo_cnt_q <= tmo_cnt_inc;
      else
        tmo_cnt_q <= 16'd0;
      if (state_q != DONE)
        tmo_q <= tmo_abort;
    end
  end

  assign Timeout_o = (state_q == DONE) && tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign Timeout_o = 1'b0;
`endif

  assign Stall_o      = Mem_Req_i && (state_q != DONE);
  assign Done_o       = (state_q == DONE);
  assign Misaligned_o = (state_q == DONE) && mis_q;
  assign Load_Data_o  = ld_q;

  assign bus.Bus_Req_o   = (state_q == REQ);
  assign bus.Bus_We_o    = we_q;
  assign bus.Bus_Addr_o  = addr_q;
  assign bus.Bus_WData_o = wdata_q;
  assign bus.Bus_Be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected completions and
// bus handshakes into queues, a negedge monitor pops and compares them.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Req_i, Mem_Write_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i, Store_Data_i;
  logic        Stall_o, Done_o, Misaligned_o, Timeout_o;
  logic [31:0] Load_Data_o;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .Mem_Req_i    (Mem_Req_i),
    .Mem_Write_i  (Mem_Write_i),
    .Funct3_i     (Funct3_i),
    .Address_i    (Address_i),
    .Store_Data_i (Store_Data_i),
    .Stall_o      (Stall_o),
    .Done_o       (Done_o),
    .Load_Data_o  (Load_Data_o),
    .Misaligned_o (Misaligned_o),
    .Timeout_o    (Timeout_o),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        tmo;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_wdata;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    resp_t r;
    bus_t  b;
    forever begin
      @(negedge clk);
      if (Done_o === 1'b1) begin
        if (resp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got Done_o=1 expected no completion");
        end else begin
          r = resp_q.pop_front();
          chk("load_data", Load_Data_o, r.ld);
          chk("misaligned", 32'(Misaligned_o), 32'(r.mis));
          chk("timeout", 32'(Timeout_o), 32'(r.tmo));
        end
      end
      if (bus.Bus_Req_o === 1'b1 && bus.Bus_Gnt_i === 1'b1) begin
        if (bus_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: got handshake expected none");
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", bus.Bus_Addr_o, b.addr);
          chk("bus_we", 32'(bus.Bus_We_o), 32'(b.we));
          chk("bus_be", 32'(bus.Bus_Be_o), 32'(b.be));
          if (b.chk_wdata) chk("bus_wdata", bus.Bus_WData_o, b.wdata);
        end
      end
    end
  end

  task automatic do_op(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic exp_mis, input logic exp_tmo, input logic [31:0] exp_ld,
                       input logic [31:0] exp_baddr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_be, input int exp_lat);
    int c, req_cnt, gcyc;
    bit done;
    resp_t r;
    bus_t  b;
    @(posedge clk); #1;
    Mem_Req_i    = 1'b1;
    Mem_Write_i  = we;
    Funct3_i     = f3;
    Address_i    = addr;
    Store_Data_i = sdata;
    r.ld = exp_ld; r.mis = exp_mis; r.tmo = exp_tmo;
    resp_q.push_back(r);
    if (!exp_mis && !exp_tmo) begin
      b.addr = exp_baddr; b.we = we; b.wdata = exp_wdata; b.be = exp_be; b.chk_wdata = we;
      bus_q.push_back(b);
    end
    c = 1; req_cnt = 0; gcyc = 0; done = 0;
    while (!done && c <= 60) begin
      bus.Bus_Gnt_i    = 1'b0;
      bus.Bus_RValid_i = 1'b0;
      if (bus.Bus_Req_o) begin
        req_cnt++;
        if (req_cnt == gnt_dly + 1) begin
          bus.Bus_Gnt_i = 1'b1;
          gcyc = c;
        end
      end
      if (gcyc != 0 && c == gcyc + rv_dly) begin
        bus.Bus_RValid_i = 1'b1;
        bus.Bus_RData_i  = rdata;
      end
      @(negedge clk);
      if (exp_mis) chk({nm, "_no_bus_req"}, 32'(bus.Bus_Req_o), 32'd0);
      if (Done_o) begin
        done = 1;
        chk({nm, "_latency"}, 32'(c), 32'(exp_lat));
        chk({nm, "_stall_done"}, 32'(Stall_o), 32'd0);
      end else begin
        chk({nm, "_stall"}, 32'(Stall_o), 32'd1);
        @(posedge clk); #1;
        c++;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_no_done: got no Done_o in 60 cycles expected %0d", nm, exp_lat);
      void'(resp_q.pop_back());
    end
    bus.Bus_Gnt_i    = 1'b0;
    bus.Bus_RValid_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Mem_Req_i = 1'b0; Mem_Write_i = 1'b0; Funct3_i = 3'd0;
    Address_i = 32'd0; Store_Data_i = 32'd0;
    bus.Bus_Gnt_i = 1'b0; bus.Bus_RValid_i = 1'b0; bus.Bus_RData_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus.Bus_Req_o), 32'd0);
    chk("rst_bus_we", 32'(bus.Bus_We_o), 32'd0);
    chk("rst_bus_addr", bus.Bus_Addr_o, 32'd0);
    chk("rst_bus_wdata", bus.Bus_WData_o, 32'd0);
    chk("rst_bus_be", 32'(bus.Bus_Be_o), 32'd0);
    chk("rst_load_data", Load_Data_o, 32'd0);
    chk("rst_done", 32'(Done_o), 32'd0);
    chk("rst_mis", 32'(Misaligned_o), 32'd0);
    chk("rst_tmo", 32'(Timeout_o), 32'd0);
    chk("rst_stall", 32'(Stall_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //     name    we  f3      addr         sdata       g  rv rdata         mis tmo exp_ld        baddr        wdata         be       lat
    do_op("sw",    1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h0,        32'h100, 32'hDEADBEEF, 4'b1111, 3);
    do_op("sb",    1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0,        0, 0, 32'h0,        32'h200, 32'hA5A5A5A5, 4'b1000, 3);
    do_op("lb",    0, 3'b000, 32'h302, 32'h0,        2, 3, 32'h0080FF00, 0, 0, 32'hFFFFFF80, 32'h300, 32'h0,        4'b1111, 8);
    do_op("lbu",   0, 3'b100, 32'h302, 32'h0,        2, 3, 32'h0080FF00, 0, 0, 32'h00000080, 32'h300, 32'h0,        4'b1111, 8);
    do_op("lh_mis",0, 3'b001, 32'h101, 32'h0,        0, 1, 32'h0,        1, 0, 32'h00000080, 32'h0,   32'h0,        4'b0000, 2);
    do_op("lw_mis",0, 3'b010, 32'h102, 32'h0,        0, 1, 32'h0,        1, 0, 32'h00000080, 32'h0,   32'h0,        4'b0000, 2);
    do_op("sh",    1, 3'b001, 32'h106, 32'h1234BEEF, 0, 0, 32'h0,        0, 0, 32'h00000080, 32'h104, 32'hBEEFBEEF, 4'b1100, 3);
    do_op("sh_lo", 1, 3'b001, 32'h104, 32'h00001234, 0, 0, 32'h0,        0, 0, 32'h00000080, 32'h104, 32'h12341234, 4'b0011, 3);
    do_op("lh",    0, 3'b001, 32'h106, 32'h0,        0, 1, 32'h80017FFF, 0, 0, 32'hFFFF8001, 32'h104, 32'h0,        4'b1111, 4);
    do_op("lhu",   0, 3'b101, 32'h104, 32'h0,        0, 1, 32'h80017FFF, 0, 0, 32'h00007FFF, 32'h104, 32'h0,        4'b1111, 4);
    do_op("lw",    0, 3'b010, 32'h208, 32'h0,        0, 1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 32'h208, 32'h0,        4'b1111, 4);
    do_op("lb_pos",0, 3'b000, 32'h501, 32'h0,        0, 1, 32'h11227F33, 0, 0, 32'h0000007F, 32'h500, 32'h0,        4'b1111, 4);
    do_op("ill_ld",0, 3'b011, 32'h0,   32'h0,        0, 1, 32'h0,        1, 0, 32'h0000007F, 32'h0,   32'h0,        4'b0000, 2);
    do_op("ill_sbu",1,3'b100, 32'h0,   32'h0,        0, 0, 32'h0,        1, 0, 32'h0000007F, 32'h0,   32'h0,        4'b0000, 2);
    do_op("ill_110",1,3'b110, 32'h0,   32'h0,        0, 0, 32'h0,        1, 0, 32'h0000007F, 32'h0,   32'h0,        4'b0000, 2);
    do_op("sh_mis",1, 3'b001, 32'h3,   32'h0,        0, 0, 32'h0,        1, 0, 32'h0000007F, 32'h0,   32'h0,        4'b0000, 2);
    do_op("sw_dly",1, 3'b010, 32'h7FC, 32'h01020304, 3, 0, 32'h0,        0, 0, 32'h0000007F, 32'h7FC, 32'h01020304, 4'b1111, 6);
    do_op("lhu_dly",0,3'b101, 32'h20,  32'h0,        1, 2, 32'h0000ABCD, 0, 0, 32'h0000ABCD, 32'h20,  32'h0,        4'b1111, 6);

    // Reset while a load sits in RESP; the late RValid must be dropped.
    @(posedge clk); #1;
    Mem_Req_i = 1'b1; Mem_Write_i = 1'b0; Funct3_i = 3'b010; Address_i = 32'h400;
    bus_q.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0, be: 4'b1111, chk_wdata: 1'b0});
    @(posedge clk); #1;
    bus.Bus_Gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", 32'(bus.Bus_Req_o), 32'd1);
    @(posedge clk); #1;
    bus.Bus_Gnt_i = 1'b0; reset = 1'b1; Mem_Req_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; bus.Bus_RValid_i = 1'b1; bus.Bus_RData_i = 32'h12345678;
    @(negedge clk);
    chk("rst_mid_bus_req", 32'(bus.Bus_Req_o), 32'd0);
    chk("rst_mid_load_data", Load_Data_o, 32'd0);
    chk("rst_mid_done", 32'(Done_o), 32'd0);
    @(posedge clk); #1;
    bus.Bus_RValid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_done_after", 32'(Done_o), 32'd0);
    chk("rst_mid_load_after", Load_Data_o, 32'd0);

    do_op("lw_rec",0, 3'b010, 32'h10,  32'h0,        0, 1, 32'hA5A50001, 0, 0, 32'hA5A50001, 32'h10,  32'h0,        4'b1111, 4);

`ifdef LSU_TIMEOUT_EN
    do_op("lw_tmo",0, 3'b010, 32'h40,  32'h0,     1000, 1, 32'h0,        0, 1, 32'h0,        32'h40,  32'h0,        4'b1111, 10);
    @(posedge clk); #1;
    Mem_Req_i = 1'b0;
    @(negedge clk);
    chk("tmo_bus_req_after", 32'(bus.Bus_Req_o), 32'd0);
`endif

    @(posedge clk); #1;
    Mem_Req_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address and turns LB/LH/LW/LBU/LHU/SB/SH/SW into a request/grant/response transaction on the data-memory bus. It aligns store data and generates byte enables, and extracts and extends load data for register write-back. It stalls the single-cycle datapath until the access completes.

## Interface
- TIMEOUT_CYCLES, 255: abort threshold in cycles, 1..65535; used only with LSU_TIMEOUT_EN.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- Mem_Req_i  in  1  current instruction is a load/store; held until Done_o.
- Mem_Write_i  in  1  1 = store, 0 = load.
- Funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- Address_i  in  32  effective address (ALU result).
- Store_Data_i  in  32  rs2 value.
- Stall_o  out  1  hold PC and suppress register write.
- Done_o  out  1  one-cycle completion pulse.
- Load_Data_o  out  32  extended load data; valid with Done_o, held until next Done_o.
- Misaligned_o  out  1  pulses with Done_o on misaligned or illegal access.
- Timeout_o  out  1  pulses with Done_o on bus timeout.
- Bus_Req_o  out  1  request.
- Bus_We_o  out  1  write.
- Bus_Addr_o  out  32  {Address_i[31:2],2'b00}.
- Bus_WData_o  out  32  lane-aligned store data.
- Bus_Be_o  out  4  byte enables.
- Bus_Gnt_i  in  1  request accepted this cycle.
- Bus_RValid_i  in  1  read data valid.
- Bus_RData_i  in  32  read data.

## Operation
- Clocking: one clock; reset is synchronous and active-high (clk, reset).
- States: IDLE, REQ, RESP, DONE.
- IDLE, Mem_Req_i=1:
  - Legal access: register address, data, size, and write flag; go to REQ.
  - Misaligned or illegal access: go to DONE with Misaligned_o; no bus activity.
- REQ:
  - Bus_Req_o=1; Bus_Addr_o, Bus_We_o, Bus_WData_o, and Bus_Be_o stay stable until grant.
  - On Bus_Gnt_i: store goes to DONE; load goes to RESP.
- RESP: wait for Bus_RValid_i, then capture, extend, and go to DONE. Bus_RValid_i is ignored outside RESP.
- DONE: Done_o=1 for one cycle, then IDLE.
- Stall_o = Mem_Req_i & (state != DONE), combinational.
- Misaligned cases:
  - H/HU/SH with Address_i[0]=1.
  - W/SW with Address_i[1:0]≠00.
- Illegal cases:
  - Funct3 011, 110, 111.
  - Stores with funct3 100 or 101.
- Stores:
  - SB: byte replicated to all four lanes; Be = 1<<addr[1:0].
  - SH: halfword replicated to both halves; Be = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: Be = 1111.
- Loads:
  - Lane selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive Be = 1111.
- Load_Data_o changes only on load completion. Stores, misaligned aborts, and timeouts leave it unchanged, except that a timed-out load sets it to 0.

## Timing
- Reset values:
  - state=IDLE.
  - Bus_Req_o, Bus_We_o, Done_o, Misaligned_o, Timeout_o = 0.
  - Bus_Addr_o, Bus_WData_o, Bus_Be_o, Load_Data_o = 0.
- Minimum latency, counted from the IDLE acceptance cycle to the Done_o cycle:
  - Store: 3 cycles (grant in the first REQ cycle).
  - Load: 4 cycles (grant, then RValid the next cycle).
  - Misaligned/illegal: 2 cycles.
- Datapath behaviour:
  - The PC advances on the clock edge that ends the DONE cycle.
  - A back-to-back memory instruction is accepted in the following IDLE cycle.
  - Mem_Req_i is not sampled in DONE.
- Bus_Req_o may stay high any number of cycles; grant and request in the same cycle complete the handshake.
- Reset mid-operation: next cycle state=IDLE and Bus_Req_o=0; any pending RValid is dropped and no Done_o is issued.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A 16-bit counter clears on leaving IDLE and increments each cycle in REQ/RESP.
  - When the count reaches TIMEOUT_CYCLES, the unit goes to DONE with Timeout_o=1 and Bus_Req_o drops.
- Undefined: no counter; the unit waits indefinitely; Timeout_o tied to 0.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, immediate grant -> Bus_Addr 0x100, Be 1111, WData 0xDEADBEEF; Done_o in cycle 3; Stall_o high in cycles 1-2.
- SB addr 0x203, data 0x000000A5 -> Be 1000, WData 0xA5A5A5A5, Bus_Addr 0x200.
- LB/LBU addr 0x302 with RData 0x0080FF00, grant delayed 2 cycles, RValid 3 cycles later -> LB: 0xFFFFFF80, LBU: 0x00000080; Done_o in cycle 8.
- LH addr 0x101, then LW addr 0x102 -> each gives Misaligned_o and Done_o in cycle 2; Bus_Req_o never asserted.
- Reset asserted during RESP, RValid arrives the next cycle -> no Done_o; Load_Data_o=0; state IDLE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, grant never given -> Timeout_o and Done_o 8 cycles after REQ entry; Bus_Req_o=0 afterwards.
